// File: rtl/timer_sched_pkg.sv
// Shared constants for the timer_sched alarm scheduler: register indices,
// scheduler states and the slot ceiling.
package timer_sched_pkg;

    localparam int unsigned MAX_SLOT = 8;

    localparam logic [3:0] DL_BASE = 4'd0;
    localparam logic [3:0] PEND    = 4'd8;
    localparam logic [3:0] ARMED   = 4'd9;
    localparam logic [3:0] TIME    = 4'd10;
    localparam logic [3:0] NEXT    = 4'd11;

    typedef enum logic [1:0] {IDLE, SCAN, WAIT} state_t;

endpackage

// File: rtl/timer_due_cmp.sv
// Wrap-aware deadline arithmetic: is deadline a due, and does a expire before b,
// both measured relative to the current system time.
module timer_due_cmp (
    input  logic [31:0] time_i,
    input  logic [31:0] a_dl,
    input  logic [31:0] b_dl,
    output logic        due,
    output logic        earlier
);

    assign due     = $signed(32'(time_i - a_dl)) >= 32'sd0;
    assign earlier = $signed(32'(a_dl - time_i)) < $signed(32'(b_dl - time_i));

endmodule

// File: rtl/timer_sched.sv
// Multi-slot alarm scheduler: scans armed slots for the earliest deadline,
// then watches time_i with a single comparator and raises pending/int_o.
module timer_sched
    import timer_sched_pkg::*;
#(
    parameter int unsigned NSLOT = 4
) (
    input  logic        wb_clk_i,
    input  logic        rst_i,
    input  logic        cyc_i,
    input  logic        stb_i,
    input  logic [3:0]  adr_i,
    input  logic        we_i,
    input  logic [31:0] dat_i,
    output logic [31:0] dat_o,
    output logic        ack_o,
    input  logic [31:0] time_i,
    output logic        int_o
);

    localparam int unsigned    IW   = $clog2(MAX_SLOT);
    localparam logic [IW-1:0]  LAST = IW'(NSLOT - 1);

    logic [31:0]      dl [NSLOT];
    logic [NSLOT-1:0] armed, pending, armed_nx, pending_nx, dl_wr;
    state_t           state;
    logic [IW-1:0]    scan_i, cand_idx, best_idx;
    logic [31:0]      cand_dl, best_dl, scan_dl;
    logic             cand_found, valid, rescan, scan_armed;
    logic             wr, cfg_wr, take, fire, start_scan;
    logic             scan_earlier, scan_due, wait_due, wait_earlier;
    logic             unused_cmp;

    assign wr     = cyc_i & stb_i & we_i;
    assign ack_o  = cyc_i & stb_i;
    assign cfg_wr = (|dl_wr) || (wr && adr_i == ARMED);

    always_comb begin
        dl_wr      = '0;
        scan_dl    = '0;
        scan_armed = 1'b0;
        for (int unsigned n = 0; n < NSLOT; n++) begin
            dl_wr[n] = wr && (adr_i == DL_BASE + 4'(n));
            if (scan_i == IW'(n)) begin
                scan_dl    = dl[n];
                scan_armed = armed[n];
            end
        end
    end

    timer_due_cmp u_scan_cmp (
        .time_i  (time_i),
        .a_dl    (scan_dl),
        .b_dl    (cand_dl),
        .due     (scan_due),
        .earlier (scan_earlier)
    );

    timer_due_cmp u_wait_cmp (
        .time_i  (time_i),
        .a_dl    (best_dl),
        .b_dl    (cand_dl),
        .due     (wait_due),
        .earlier (wait_earlier)
    );

    assign unused_cmp = scan_due ^ wait_earlier;

    // Strict "earlier" keeps the lower index on ties since slots are visited in order.
    assign take       = scan_armed && (!cand_found || scan_earlier);
    assign fire       = (state == WAIT) && wait_due;
    assign start_scan = rescan || fire;

    // Order matters: fire sets pending over W1C, a DL write re-arms over the fire clear.
    always_comb begin
        armed_nx   = armed;
        pending_nx = pending;
        if (wr && adr_i == PEND)
            pending_nx = pending & ~dat_i[NSLOT-1:0];
        for (int unsigned n = 0; n < NSLOT; n++) begin
            if (fire && best_idx == IW'(n)) begin
                pending_nx[n] = 1'b1;
                armed_nx[n]   = 1'b0;
            end
        end
        if (wr && adr_i == ARMED)
            armed_nx = armed_nx & ~dat_i[NSLOT-1:0];
        armed_nx = armed_nx | dl_wr;
    end

    always_comb begin
        dat_o = '0;
        case (adr_i)
            PEND:    dat_o = 32'(pending);
            ARMED:   dat_o = 32'(armed);
            TIME:    dat_o = time_i;
            NEXT:    dat_o = {valid, 4'b0, best_idx, 24'b0};
            default: begin
                for (int unsigned n = 0; n < NSLOT; n++)
                    if (adr_i == DL_BASE + 4'(n))
                        dat_o = dl[n];
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge rst_i) begin
        if (rst_i) begin
            armed      <= '0;
            pending    <= '0;
            int_o      <= 1'b0;
            for (int unsigned n = 0; n < NSLOT; n++)
                dl[n] <= '0;
            state      <= IDLE;
            scan_i     <= '0;
            cand_idx   <= '0;
            cand_dl    <= '0;
            cand_found <= 1'b0;
            best_idx   <= '0;
            best_dl    <= '0;
            valid      <= 1'b0;
            rescan     <= 1'b0;
        end else begin
            armed   <= armed_nx;
            pending <= pending_nx;
            int_o   <= |pending;
            for (int unsigned n = 0; n < NSLOT; n++)
                if (dl_wr[n])
                    dl[n] <= dat_i;

            // A fire or rescan from any state restarts the scan at slot 0.
            if (start_scan) begin
                state      <= SCAN;
                scan_i     <= '0;
                cand_found <= 1'b0;
                valid      <= 1'b0;
                rescan     <= 1'b0;
            end else if (state == SCAN) begin
                if (scan_i == LAST) begin
                    if (cand_found || take) begin
                        best_idx <= take ? scan_i : cand_idx;
                        best_dl  <= take ? scan_dl : cand_dl;
                        valid    <= 1'b1;
                        state    <= WAIT;
                    end else begin
                        state    <= IDLE;
                    end
                end else begin
                    scan_i <= scan_i + 1'b1;
                    if (take) begin
                        cand_idx   <= scan_i;
                        cand_dl    <= scan_dl;
                        cand_found <= 1'b1;
                    end
                end
            end

            if (cfg_wr)
                rescan <= 1'b1;
        end
    end

endmodule
